door_open_alarm_multi: RTL

- Multi-door successor to the single-door open-warning block in the appliance controller.
- Watches N_DOORS independent door_open inputs, each with its own timer.
- Raises a per-door warning after WARN_CYCLES consecutive open cycles and a shared escalated alarm after ALARM_CYCLES.
- An acknowledge snoozes active warnings; the block also reports a live count of open doors to the display/status logic.

---
 rtl/door_open_alarm_multi.sv | 136 +++++++++++++
 1 files changed

// File: rtl/door_open_alarm_multi.sv
// Per-door open timers with warn/alarm escalation, ack snooze and live open-door count; DOOR_SYNC_EN adds 2-flop input synchronisers.
// Latency: all outputs registered, 1 cycle after the sampling edge (plus 2 cycles when DOOR_SYNC_EN is defined).
// Backpressure: none; level inputs are sampled every clock and cannot be stalled.
module door_open_alarm_multi #(
   parameter int N_DOORS       = 4,
   parameter int WARN_CYCLES   = 20,
   parameter int ALARM_CYCLES  = 40,
   parameter int SNOOZE_CYCLES = 30,
   parameter int CNT_W         = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [N_DOORS-1:0] door_open,
   input  logic               ack,
   output logic [N_DOORS-1:0] warn,
   output logic               alarm,
   output logic [3:0]         open_count
);

   localparam logic [1:0] ST_CLOSED   = 2'd0;
   localparam logic [1:0] ST_COUNTING = 2'd1;
   localparam logic [1:0] ST_WARN     = 2'd2;
   localparam logic [1:0] ST_SNOOZED  = 2'd3;

   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] WARN_T   = CNT_W'(WARN_CYCLES);
   localparam logic [CNT_W-1:0] ALARM_T  = CNT_W'(ALARM_CYCLES);
   localparam logic [CNT_W-1:0] SNOOZE_T = CNT_W'(SNOOZE_CYCLES);

   logic [N_DOORS-1:0] door_q;
   logic               ack_q;

`ifdef DOOR_SYNC_EN
   logic [N_DOORS-1:0] door_s1, door_s2;
   logic               ack_s1, ack_s2;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         door_s1 <= '0;
         door_s2 <= '0;
         ack_s1  <= 1'b0;
         ack_s2  <= 1'b0;
      end else begin
         door_s1 <= door_open;
         door_s2 <= door_s1;
         ack_s1  <= ack;
         ack_s2  <= ack_s1;
      end
   end

   assign door_q = door_s2;
   assign ack_q  = ack_s2;
`else
   assign door_q = door_open;
   assign ack_q  = ack;
`endif

   logic [N_DOORS-1:0][1:0]       state_r, state_nxt;
   logic [N_DOORS-1:0][CNT_W-1:0] timer_r, timer_nxt;
   logic [N_DOORS-1:0]            esc_r, esc_nxt;
   logic [N_DOORS-1:0]            warn_nxt;
   logic [3:0]                    cnt_nxt;

   always_comb begin
      cnt_nxt = 4'd0;
      for (int i = 0; i < N_DOORS; i++) begin
         state_nxt[i] = state_r[i];
         timer_nxt[i] = timer_r[i];
         esc_nxt[i]   = esc_r[i];
         cnt_nxt      = cnt_nxt + {3'd0, door_q[i]};
         // A closed door dominates every other condition, including ack.
         if (!door_q[i]) begin
            state_nxt[i] = ST_CLOSED;
            timer_nxt[i] = '0;
            esc_nxt[i]   = 1'b0;
         end else begin
            case (state_r[i])
               ST_CLOSED: begin
                  timer_nxt[i] = ONE;
                  state_nxt[i] = (WARN_CYCLES == 1) ? ST_WARN : ST_COUNTING;
               end
               ST_COUNTING: begin
                  timer_nxt[i] = timer_r[i] + ONE;
                  if (timer_r[i] + ONE == WARN_T)
                     state_nxt[i] = ST_WARN;
               end
               ST_WARN: begin
                  if (ack_q) begin
                     state_nxt[i] = ST_SNOOZED;
                     timer_nxt[i] = '0;
                     esc_nxt[i]   = 1'b0;
                  end else begin
                     timer_nxt[i] = (timer_r[i] == ALARM_T) ? timer_r[i] : timer_r[i] + ONE;
                     if (timer_nxt[i] == ALARM_T)
                        esc_nxt[i] = 1'b1;
                  end
               end
               ST_SNOOZED: begin
                  // Resume at the warn threshold so escalation keeps its original spacing.
                  if (timer_r[i] + ONE == SNOOZE_T) begin
                     state_nxt[i] = ST_WARN;
                     timer_nxt[i] = WARN_T;
                  end else begin
                     timer_nxt[i] = timer_r[i] + ONE;
                  end
               end
               default: begin
                  state_nxt[i] = ST_CLOSED;
                  timer_nxt[i] = '0;
                  esc_nxt[i]   = 1'b0;
               end
            endcase
         end
         warn_nxt[i] = (state_nxt[i] == ST_WARN);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r    <= '0;
         timer_r    <= '0;
         esc_r      <= '0;
         warn       <= '0;
         alarm      <= 1'b0;
         open_count <= 4'd0;
      end else begin
         state_r    <= state_nxt;
         timer_r    <= timer_nxt;
         esc_r      <= esc_nxt;
         warn       <= warn_nxt;
         alarm      <= |esc_nxt;
         open_count <= cnt_nxt;
      end
   end

endmodule
